// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared types and constants for the SRAM port arbiter
package sram_arbiter_pkg;
    localparam int RAM_ADDR_W = 20;
    typedef logic Bit_t;
    typedef logic [31:0] Word_t;
    typedef logic [RAM_ADDR_W-1:0] Ram_addr_t;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} Arb_state_t;
    typedef enum logic {OWNER_IF, OWNER_MEM} Arb_owner_t;
endpackage

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin IF/MEM arbiter serialising accesses onto one SRAM controller
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ACCESS_CYCLES = 3,
    parameter int RAM_ADDR_W = sram_arbiter_pkg::RAM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic [31:0]           if_rdata,
    output logic                  if_stall,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_be,
    output logic [31:0]           mem_rdata,
    output logic                  mem_stall,
    output logic                  sc_read_op,
    output logic                  sc_write_op,
    output logic [RAM_ADDR_W-1:0] sc_addr,
    output logic [3:0]            sc_byte_mask,
    output logic [31:0]           sc_wdata,
    input  logic [31:0]           sc_rdata
);
    localparam int CW = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES);

    Arb_state_t    state;
    Arb_owner_t    last_owner;
    logic [CW-1:0] cnt;
    logic          mem_req, pick_mem, pick_wr, unused;

    assign mem_req   = mem_rd | mem_wr;
    // MEM wins when alone, or when both request and IF had the previous grant
    assign pick_mem  = mem_req & (~if_req | (last_owner == OWNER_IF));
    assign pick_wr   = pick_mem & mem_wr;
    assign if_stall  = if_req & ~(state == S_DONE && last_owner == OWNER_IF);
    assign mem_stall = mem_req & ~(state == S_DONE && last_owner == OWNER_MEM);
    assign unused    = ^{if_addr[31:RAM_ADDR_W+2], if_addr[1:0], mem_addr[31:RAM_ADDR_W+2], mem_addr[1:0]};

    // grant in idle, hold the strobe for ACCESS_CYCLES, capture read data, then one done cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            last_owner   <= OWNER_IF;
            sc_read_op   <= 1'b0;
            sc_write_op  <= 1'b0;
            sc_addr      <= '0;
            sc_byte_mask <= '0;
            sc_wdata     <= '0;
            if_rdata     <= '0;
            mem_rdata    <= '0;
        end else begin
            case (state)
                S_IDLE: if (if_req | mem_req) begin
                    last_owner   <= pick_mem ? OWNER_MEM : OWNER_IF;
                    sc_addr      <= pick_mem ? mem_addr[RAM_ADDR_W+1:2] : if_addr[RAM_ADDR_W+1:2];
                    sc_byte_mask <= pick_wr ? mem_be : 4'hF;
                    sc_wdata     <= mem_wdata;
                    sc_write_op  <= pick_wr;
                    sc_read_op   <= ~pick_wr;
                    cnt          <= CW'(1);
                    state        <= S_ACCESS;
                end
                S_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        if (sc_read_op && last_owner == OWNER_IF) if_rdata <= sc_rdata;
                        if (sc_read_op && last_owner == OWNER_MEM) mem_rdata <= sc_rdata;
                        sc_read_op  <= 1'b0;
                        sc_write_op <= 1'b0;
                        cnt         <= '0;
                        state       <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench with an SRAM model and a transaction-level reference
module tb_sram_arbiter;
    localparam int AC = 3;

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        if_req = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, sc_rdata = '0;
    logic [3:0]  mem_be = '0;
    logic [31:0] if_rdata, mem_rdata, sc_wdata;
    logic        if_stall, mem_stall, sc_read_op, sc_write_op;
    logic [19:0] sc_addr;
    logic [3:0]  sc_byte_mask;

    int vectors = 0, miscompares = 0;
    req_t if_q[$], mem_q[$];
    logic [19:0] grant_log[$];
    logic [31:0] sram[logic [19:0]];
    logic [31:0] ref_mem[logic [19:0]];

    always #5 clk = ~clk;

    sram_arbiter #(.ACCESS_CYCLES(AC), .RAM_ADDR_W(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .sc_read_op(sc_read_op), .sc_write_op(sc_write_op), .sc_addr(sc_addr),
        .sc_byte_mask(sc_byte_mask), .sc_wdata(sc_wdata), .sc_rdata(sc_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [19:0] a);
        return {a[11:0], a} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic void ref_wr(input req_t r);
        logic [31:0] w;
        w = ref_rd(r.addr);
        for (int b = 0; b < 4; b++) if (r.mask[b]) w[8*b +: 8] = r.wdata[8*b +: 8];
        ref_mem[r.addr] = w;
    endfunction

    // SRAM behind the controller: read data valid while the read strobe is held, junk otherwise
    always @(negedge clk)
        sc_rdata = sc_read_op ? (sram.exists(sc_addr) ? sram[sc_addr] : init_word(sc_addr)) : $urandom;

    // SRAM write port, driven by whatever the arbiter actually presents
    always @(posedge clk) begin : sram_wr
        logic [31:0] w;
        if (sc_write_op) begin
            w = sram.exists(sc_addr) ? sram[sc_addr] : init_word(sc_addr);
            for (int b = 0; b < 4; b++) if (sc_byte_mask[b]) w[8*b +: 8] = sc_wdata[8*b +: 8];
            sram[sc_addr] = w;
        end
    end

    // monitor: detect grants, predict the winner, check hold window, stalls and read data
    int          phase = 0, hi = 0;
    logic        cur_mem = 1'b0, ref_last_mem = 1'b0, prev_if = 1'b0, prev_mem = 1'b0, mreq, done;
    req_t        cur;
    logic [31:0] exp_rd = '0;

    always @(negedge clk) begin
        mreq = mem_rd | mem_wr;
        done = 1'b0;
        if (!rst_n) begin
            phase = 0;
            ref_last_mem = 1'b0;
        end else begin
            if (phase == 0 && (sc_read_op || sc_write_op)) begin
                check("grant_had_request", prev_if | prev_mem, 1);
                cur_mem = prev_mem && (!prev_if || !ref_last_mem);
                ref_last_mem = cur_mem;
                if ((cur_mem ? mem_q.size() : if_q.size()) == 0) begin
                    check("grant_queue_nonempty", 0, 1);
                    cur = '{wr: sc_write_op, addr: sc_addr, mask: sc_byte_mask, wdata: sc_wdata};
                end else cur = cur_mem ? mem_q.pop_front() : if_q.pop_front();
                exp_rd = ref_rd(cur.addr);
                if (cur.wr) ref_wr(cur);
                grant_log.push_back(sc_addr);
                check("grant_cmd", {sc_write_op, sc_read_op, sc_addr, sc_byte_mask},
                      {cur.wr, ~cur.wr, cur.addr, cur.mask});
                if (cur.wr) check("grant_wdata", sc_wdata, cur.wdata);
                hi = 1;
                phase = 1;
            end else if (phase == 1 && (sc_read_op || sc_write_op)) begin
                hi++;
                check("hold_cmd", {sc_write_op, sc_read_op, sc_addr, sc_byte_mask},
                      {cur.wr, ~cur.wr, cur.addr, cur.mask});
            end else if (phase == 1) begin
                done = 1'b1;
                phase = 0;
                check("strobe_cycles", hi, AC);
                check("owner_stall", cur_mem ? mem_stall : if_stall, 0);
                check("other_stall", cur_mem ? if_stall : mem_stall, cur_mem ? if_req : mreq);
                if (!cur.wr) check(cur_mem ? "mem_rdata" : "if_rdata", cur_mem ? mem_rdata : if_rdata, exp_rd);
            end
            if (!done) begin
                check("if_stall", if_stall, if_req);
                check("mem_stall", mem_stall, mreq);
            end
        end
        prev_if = if_req;
        prev_mem = mreq;
    end

    task automatic do_if(input logic [31:0] a, output int n);
        if_q.push_back('{wr: 1'b0, addr: a[21:2], mask: 4'hF, wdata: 32'h0});
        if_addr = a;
        if_req = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (!if_stall) break;
            n++;
            if (n > 40) begin check("if_stall_timeout", n, 0); break; end
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic do_mem(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, output int n);
        mem_q.push_back('{wr: wr, addr: a[21:2], mask: wr ? be : 4'hF, wdata: wd});
        mem_addr = a;
        mem_wdata = wd;
        mem_be = be;
        mem_rd = rd;
        mem_wr = wr;
        n = 0;
        forever begin
            @(negedge clk);
            if (!mem_stall) break;
            n++;
            if (n > 40) begin check("mem_stall_timeout", n, 0); break; end
        end
        @(posedge clk); #1;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_strobe(input logic wr);
        for (int k = 0; k < 20 && !(wr ? sc_write_op : sc_read_op); k++) @(negedge clk);
        check("strobe_seen", wr ? sc_write_op : sc_read_op, 1);
    endtask

    function automatic logic [31:0] rand_addr(input int base);
        return ($urandom & 32'hFFC0_0003) | (32'(base + $urandom_range(0, 7)) << 2);
    endfunction

    int ni, nm;

    initial begin
        #1 rst_n = 1'b0;
        if_req = 1'b1;
        mem_rd = 1'b1;
        #1;
        check("rst_if_stall", if_stall, 1);
        check("rst_mem_stall", mem_stall, 1);
        check("rst_outputs", {sc_read_op, sc_write_op, sc_addr, sc_byte_mask}, 0);
        check("rst_wdata_rdata", {sc_wdata, if_rdata | mem_rdata}, 0);
        if_req = 1'b0;
        mem_rd = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // single IF read
        sram[20'h4] = 32'hDEAD_BEEF;
        ref_mem[20'h4] = 32'hDEAD_BEEF;
        do_if(32'h0000_0010, ni);
        check("if_latency", ni, AC + 1);
        check("if_rdata_beef", if_rdata, 32'hDEAD_BEEF);

        // MEM byte write
        fork
            do_mem(1'b0, 1'b1, 32'h0000_0104, 32'h0000_AB00, 4'b0010, nm);
            begin
                wait_strobe(1'b1);
                check("wr_fields", {sc_addr, sc_byte_mask, sc_wdata}, {20'h00041, 4'b0010, 32'h0000_AB00});
            end
        join
        check("mem_latency", nm, AC + 1);

        // simultaneous requests straight out of reset: MEM first, then IF
        do_reset();
        fork
            do_mem(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, nm);
            do_if(32'h0000_0300, ni);
        join
        check("sim_mem_latency", nm, AC + 1);
        check("sim_if_latency", ni, 2 * (AC + 2) - 1);

        // continuous requests alternate MEM, IF, MEM, IF, ...
        grant_log.delete();
        fork
            for (int i = 0; i < 3; i++) begin
                int n;
                do_mem(1'b1, 1'b0, 32'(32'h400 + i * 4), 32'h0, 4'h0, n);
            end
            for (int i = 0; i < 3; i++) begin
                int n;
                do_if(32'(32'h800 + i * 4), n);
            end
        join
        check("alt_count", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check("alt_order", grant_log[i], (i % 2 == 0) ? 20'h100 + 20'(i / 2) : 20'h200 + 20'(i / 2));

        // MEM read withdrawn during the second access cycle
        mem_q.push_back('{wr: 1'b0, addr: 20'h00055, mask: 4'hF, wdata: 32'h0});
        mem_addr = 32'h0000_0154;
        mem_rd = 1'b1;
        wait_strobe(1'b0);
        @(posedge clk); #1 mem_rd = 1'b0;
        repeat (4) @(negedge clk);
        check("withdraw_mem_rdata", mem_rdata, init_word(20'h00055));
        @(posedge clk); #1;
        do_if(32'h0000_0020, ni);
        check("after_withdraw_latency", ni, AC + 1);

        // reset during the second cycle of a write; the held request is granted again
        fork
            do_mem(1'b0, 1'b1, 32'h0000_0180, 32'h1234_5678, 4'b1001, nm);
            begin
                wait_strobe(1'b1);
                @(posedge clk); #2 rst_n = 1'b0;
                #1;
                check("rst_mid_write_strobe", {sc_write_op, sc_read_op}, 0);
                check("rst_mid_write_stall", mem_stall, 1);
                mem_q.push_back('{wr: 1'b1, addr: 20'h00060, mask: 4'b1001, wdata: 32'h1234_5678});
                @(posedge clk); #2 rst_n = 1'b1;
            end
        join
        check("regrant_data", sram.exists(20'h00060) ? sram[20'h00060] : 32'h0,
              (init_word(20'h00060) & 32'h00FF_FF00) | 32'h1200_0078);

        // randomized traffic on both ports
        @(posedge clk); #1;
        fork
            for (int i = 0; i < 25; i++) begin
                int n, g;
                logic [1:0] op;
                op = 2'($urandom_range(1, 3));
                do_mem(op[0], op[1], rand_addr(16), $urandom, 4'($urandom_range(0, 15)), n);
                g = $urandom_range(0, 3);
                repeat (g) begin @(posedge clk); #1; end
            end
            for (int i = 0; i < 25; i++) begin
                int n, g;
                do_if(rand_addr(16), n);
                g = $urandom_range(0, 3);
                repeat (g) begin @(posedge clk); #1; end
            end
        join

        repeat (5) @(negedge clk);
        check("if_queue_drained", if_q.size(), 0);
        check("mem_queue_drained", mem_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sits directly upstream of the SRAM controller and converts two CPU-side memory ports into one serialized single-port SRAM transaction stream.
- The two ports are the instruction-fetch (IF) port and the load/store (MEM) port.
- Arbitrates between the ports, holds the controller's read/write strobes for the full access window, and captures read data.
- Drives per-port stall signals back to the pipeline until each port's access completes.

Parameters:
- ACCESS_CYCLES, 3: cycles a strobe is held asserted toward the controller (≥2).
- RAM_ADDR_W, 20: word-address width toward the SRAM (matches Ram_addr_t).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- if_req  input  1  IF read request, held until if_stall low
- if_addr  input  32  IF byte address
- if_rdata  output  32  fetched word, valid in the cycle if_stall drops
- if_stall  output  1  IF must hold request
- mem_rd  input  1  MEM read request
- mem_wr  input  1  MEM write request
- mem_addr  input  32  MEM byte address
- mem_wdata  input  32  store data
- mem_be  input  4  byte enables, active-high
- mem_rdata  output  32  load word, valid in the cycle mem_stall drops
- mem_stall  output  1  MEM must hold request
- sc_read_op  output  1  read strobe to controller
- sc_write_op  output  1  write strobe to controller
- sc_addr  output  RAM_ADDR_W  word address (byte address bits [RAM_ADDR_W+1:2])
- sc_byte_mask  output  4  byte mask to controller
- sc_wdata  output  32  write data; top-level glue drives the shared bus from it while sc_write_op=1
- sc_rdata  input  32  read data from controller bus

Behaviour:
- Reset (rst_n=0, immediate, asynchronous):
  - state=S_IDLE, cnt=0, last_owner=IF.
  - sc_read_op, sc_write_op, sc_addr, sc_byte_mask, sc_wdata, if_rdata, mem_rdata all 0.
  - Stalls are combinational: during reset, if_stall=if_req and mem_stall=mem_rd|mem_wr.
- State S_IDLE:
  - No request: stay in S_IDLE, strobes 0.
  - On a clock edge with a pending request: pick an owner; latch sc_addr, sc_byte_mask and sc_wdata; assert the strobe; cnt←1; go to S_ACCESS.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both requesting: the port that is not last_owner wins (round-robin), so neither port starves.
  - Owner is recorded in last_owner at grant.
- MEM request encoding:
  - mem_wr=1 gives a write with sc_byte_mask=mem_be and sc_wdata=mem_wdata.
  - mem_rd=1 alone gives a read with sc_byte_mask=4'b1111.
  - mem_rd=1 and mem_wr=1 together is treated as a write.
  - mem_be=0 on a write is still issued (no RAM byte changes).
- IF requests are always reads with sc_byte_mask=4'b1111.
- State S_ACCESS:
  - Strobe, address, mask and wdata are held constant; cnt increments each edge.
  - On the edge where cnt==ACCESS_CYCLES: sample sc_rdata into the owner's rdata register (reads only), drop both strobes, go to S_DONE.
  - Strobe high time is exactly ACCESS_CYCLES cycles.
- State S_DONE:
  - Strobes are 0, which guarantees one low cycle between consecutive transactions.
  - The owner's stall is 0 for exactly this cycle; next edge goes to S_IDLE.
- Stall equations:
  - if_stall = if_req & ~(S_DONE & owner==IF).
  - mem_stall = (mem_rd|mem_wr) & ~(S_DONE & owner==MEM).
- Latency: request seen in S_IDLE to stall low = ACCESS_CYCLES+1 cycles; back-to-back throughput is one access per ACCESS_CYCLES+2 cycles.
- rdata registers hold their value until the next read by the same port overwrites them.
- Request withdrawn mid-access: the transaction completes unchanged and its result is discarded. A write still lands.
- Request changed mid-access (new address): ignored until the next S_IDLE grant.
- Reset asserted mid-access: strobes drop asynchronously and the access is abandoned. Partial-write corruption is accepted.

Decomposition:
- Shared package (defines.svh) holds:
  - Arb_state_t {S_IDLE, S_ACCESS, S_DONE}
  - Arb_owner_t {OWNER_IF, OWNER_MEM}
  - RAM_ADDR_W
  - existing Bit_t, Word_t, Ram_addr_t
- Single module, no sub-module; the counter and owner register are inline.

Test Plan:
- Single IF read: if_req=1, if_addr=0x0000_0010, sc_rdata=0xDEADBEEF.
  - sc_read_op high 3 cycles with sc_addr=0x00004.
  - if_stall low 4 cycles after the request; if_rdata=0xDEADBEEF.
- MEM byte write: mem_wr=1, addr=0x0000_0104, be=4'b0010, wdata=0x0000AB00.
  - sc_write_op high 3 cycles; sc_addr=0x00041, sc_byte_mask=4'b0010, sc_wdata=0x0000AB00.
  - mem_stall drops in S_DONE.
- Simultaneous IF+MEM, both held after reset (last_owner=IF):
  - MEM granted first, then IF.
  - Strobes low for ≥1 cycle between the two.
  - Total 10 cycles to both stalls released.
- Continuous IF+MEM requests for 6 accesses: grants alternate MEM,IF,MEM,IF,MEM,IF.
- Withdraw mem_rd in cycle 2 of access: strobe still held 3 cycles; mem_rdata is updated (capture is unconditional) but never consumed; next grant proceeds normally.
- rst_n low during cycle 2 of a write: sc_write_op=0 in the same cycle (asynchronous); state S_IDLE after release; the pending request is re-granted.
